// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared word type, constants, FSM encodings and PC helper for the IF stage
package fetch_stage_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t ZERO   = '0;
    localparam word_t NOP    = ZERO;
    localparam word_t PC_INC = 32'd4;

    // Fetch FSM encodings
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Sequential PC; wraps modulo 2^WORD_W
    function automatic word_t pc_plus4(input word_t pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/rdy port between fetch stage and imem
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  req;
    word_t addr;
    logic  rdy;
    word_t data;

    modport master (output req, output addr, input rdy, input data);
    modport slave  (input req, input addr, output rdy, output data);

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter with load, increment and hold
module fetch_stage_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC = ZERO
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  word_t load_pc,
    input  logic  inc,
    output word_t pc,
    output word_t pc_next
);

    assign pc_next = pc_plus4(pc);

    // Load wins over increment; otherwise the PC holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, imem fetch FSM, stall hold and redirect squash (FETCH_MISALIGN_EN optional)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC = ZERO
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect,
    input  word_t           redirect_pc,
    fetch_stage_if.master   imem,
    output word_t           nPC_if,
    output word_t           IR_if,
    output logic            if_valid,
    output logic            misalign
);

    logic [1:0] state;
    logic       squash;
    word_t      squash_addr;
    word_t      hold_ir;
    word_t      pc;
    word_t      pc_next;
    word_t      load_val;
    logic       halted;
    logic       transfer;
    logic       pc_inc;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;

    assign load_val = redirect_pc;
    assign halted   = misalign_q;
    assign misalign = misalign_q;

    // Sticky flag: any misaligned redirect target stops fetching until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    localparam word_t ALIGN_MASK = ~word_t'(32'h3);

    assign load_val = redirect_pc & ALIGN_MASK;
    assign halted   = 1'b0;
    assign misalign = 1'b0;
`endif

    // A squashed request keeps its original address until the memory answers,
    // even when halted, so the outstanding transfer can complete.
    assign imem.req  = (state != S_HOLD) && (!halted || squash);
    assign imem.addr = squash ? squash_addr : pc;
    assign transfer  = imem.req && imem.rdy;

    // PC advances when an instruction is actually handed to IF/ID
    assign pc_inc = !redirect && !stall &&
                    ((transfer && !squash) || (state == S_HOLD));

    fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (redirect),
        .load_pc (load_val),
        .inc     (pc_inc),
        .pc      (pc),
        .pc_next (pc_next)
    );

    // Fetch FSM plus IF/ID output registers; redirect beats transfer beats stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_REQ;
            squash      <= 1'b0;
            squash_addr <= ZERO;
            hold_ir     <= ZERO;
            nPC_if      <= ZERO;
            IR_if       <= ZERO;
            if_valid    <= 1'b0;
        end else if (redirect) begin
            IR_if    <= NOP;
            if_valid <= 1'b0;
            if (imem.req && !transfer) begin
                // Request still in flight: keep asking for the old address and drop its word
                state  <= S_WAIT;
                squash <= 1'b1;
                if (!squash) begin
                    squash_addr <= pc;
                end
            end else begin
                state  <= S_REQ;
                squash <= 1'b0;
            end
        end else if (transfer) begin
            if (squash) begin
                squash <= 1'b0;
                state  <= S_REQ;
            end else if (stall) begin
                hold_ir <= imem.data;
                state   <= S_HOLD;
            end else begin
                IR_if    <= imem.data;
                nPC_if   <= pc_next;
                if_valid <= 1'b1;
                state    <= S_REQ;
            end
        end else if (state == S_HOLD) begin
            if (!stall) begin
                IR_if    <= hold_ir;
                nPC_if   <= pc_next;
                if_valid <= 1'b1;
                state    <= S_REQ;
            end
        end else begin
            if (imem.req) begin
                state <= S_WAIT;
            end
            // No new word and not stalled: hand IF/ID a bubble instead of a duplicate
            if (!stall) begin
                IR_if    <= NOP;
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] npc_if;
    logic [31:0] ir_if;
    logic        if_valid;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic        mon_stall;
    logic        mon_rst;
    logic [63:0] mon_exp;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .nPC_if      (npc_if),
        .IR_if       (ir_if),
        .if_valid    (if_valid),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every fresh instruction handed to IF/ID must match the queue head
    always @(posedge clk) begin
        mon_stall = stall;
        mon_rst   = reset_n;
        #1;
        if (mon_rst && if_valid && !mon_stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got IR_if=%h nPC_if=%h, required no instruction", ir_if, npc_if);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ir_if, npc_if} !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_instr: got IR_if=%h nPC_if=%h, required IR_if=%h nPC_if=%h",
                             ir_if, npc_if, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem.rdy = 1'b0; imem.data = '0;
        repeat (3) step();
        checks++;
        if ({ir_if, npc_if, if_valid, misalign} !== 66'd0) begin
            failures++;
            $display("FAIL reset_outputs: got IR=%h nPC=%h v=%b m=%b, required all 0", ir_if, npc_if, if_valid, misalign);
        end
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_fetch: got req=%b addr=%h, required req=1 addr=0", imem.req, imem.addr);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        words[0] = 32'h20080001; words[1] = 32'h20090002;
        words[2] = 32'h012A4020; words[3] = 32'hAC080004;
        imem.rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem.addr !== 32'(4 * i)) begin
                failures++;
                $display("FAIL stream_addr%0d: got %h, required %h", i, imem.addr, 32'(4 * i));
            end
            imem.data = words[i];
            exp_q.push_back({words[i], 32'(4 * i + 4)});
            step();
            checks++;
            if (if_valid !== 1'b1) begin
                failures++;
                $display("FAIL stream_valid%0d: got %b, required 1", i, if_valid);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        imem.rdy = 1'b0; stall = 1'b1;
        step();
        checks++;
        if (ir_if !== 32'hAC080004 || if_valid !== 1'b1 || imem.addr !== 32'h10) begin
            failures++;
            $display("FAIL wait_hold: got IR=%h v=%b addr=%h, required IR=ac080004 v=1 addr=00000010", ir_if, if_valid, imem.addr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ir_if, npc_if, if_valid, misalign} !== 66'd0 || imem.addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got IR=%h nPC=%h v=%b addr=%h, required zeros", ir_if, npc_if, if_valid, imem.addr);
        end
        stall = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_release_addr: got req=%b addr=%h, required req=1 addr=0", imem.req, imem.addr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem.rdy = 1'b1; imem.data = 32'h8C0A0000;
        exp_q.push_back({32'h8C0A0000, 32'h4});
        step();
        imem.data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem.req !== 1'b0 || if_valid !== 1'b0 || ir_if !== 32'h0) begin
                failures++;
                $display("FAIL stall_hold%0d: got req=%b v=%b IR=%h, required req=0 v=0 IR=0", i, imem.req, if_valid, ir_if);
            end
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        checks++;
        if (ir_if !== 32'h8C0A0000 || imem.addr !== 32'h4) begin
            failures++;
            $display("FAIL stall_release: got IR=%h addr=%h, required IR=8c0a0000 addr=00000004", ir_if, imem.addr);
        end
        imem.data = 32'h01095020;
        exp_q.push_back({32'h01095020, 32'h8});
        step();
        imem.rdy = 1'b0;
        step();
    endtask

    task automatic test_redirect_wait();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem.req !== 1'b1 || imem.addr !== 32'h8 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL squash_wait%0d: got req=%b addr=%h v=%b, required req=1 addr=00000008 v=0", i, imem.req, imem.addr, if_valid);
            end
            step();
        end
        imem.rdy = 1'b1; imem.data = 32'h11111111;
        step();
        checks++;
        if (if_valid !== 1'b0 || imem.addr !== 32'h40) begin
            failures++;
            $display("FAIL squash_drop: got v=%b addr=%h, required v=0 addr=00000040", if_valid, imem.addr);
        end
        imem.data = 32'h22222222;
        exp_q.push_back({32'h22222222, 32'h44});
        step();
    endtask

    task automatic test_redirect_transfer_stall();
        imem.rdy = 1'b1; imem.data = 32'h33333333;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        checks++;
        if (ir_if !== 32'h0 || if_valid !== 1'b0 || imem.addr !== 32'h100 || imem.req !== 1'b1) begin
            failures++;
            $display("FAIL redirect_xfer: got IR=%h v=%b addr=%h req=%b, required IR=0 v=0 addr=00000100 req=1", ir_if, if_valid, imem.addr, imem.req);
        end
        redirect = 1'b0; stall = 1'b0; imem.data = 32'h44444444;
        exp_q.push_back({32'h44444444, 32'h104});
        step();
        imem.rdy = 1'b0;
        step();
        stall = 1'b1; imem.rdy = 1'b1; imem.data = 32'h77777777;
        step();
        redirect = 1'b1; redirect_pc = 32'h200; imem.rdy = 1'b0;
        step();
        redirect = 1'b0; stall = 1'b0;
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h200 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_hold: got req=%b addr=%h v=%b, required req=1 addr=00000200 v=0", imem.req, imem.addr, if_valid);
        end
        step();
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC; imem.rdy = 1'b1; imem.data = 32'hBADBAD00;
        step();
        redirect = 1'b0;
        imem.data = 32'h03E00008;
        exp_q.push_back({32'h03E00008, 32'h0});
        step();
        checks++;
        if (npc_if !== 32'h0 || imem.addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap: got nPC=%h addr=%h, required both 00000000", npc_if, imem.addr);
        end
        imem.rdy = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h340;
        step();
        redirect = 1'b0;
        step();
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_wait: got req=%b addr=%h v=%b, required req=1 addr=0 v=0", imem.req, imem.addr, if_valid);
        end
        imem.rdy = 1'b1; imem.data = 32'hBADBAD01;
        step();
        checks++;
        if (imem.addr !== 32'h340 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_last_wins: got addr=%h v=%b, required addr=00000340 v=0", imem.addr, if_valid);
        end
        imem.data = 32'h55555555;
        exp_q.push_back({32'h55555555, 32'h344});
        step();
        imem.rdy = 1'b0;
        step();
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
        checks++;
        if (misalign !== 1'b1 || imem.req !== 1'b1 || imem.addr !== 32'h344) begin
            failures++;
            $display("FAIL misalign_set: got m=%b req=%b addr=%h, required m=1 req=1 addr=00000344", misalign, imem.req, imem.addr);
        end
        imem.rdy = 1'b1; imem.data = 32'hBADBAD02;
        step();
        checks++;
        if (misalign !== 1'b1 || imem.req !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_halt: got m=%b req=%b v=%b, required m=1 req=0 v=0", misalign, imem.req, if_valid);
        end
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        step();
        checks++;
        if (misalign !== 1'b1 || imem.req !== 1'b0) begin
            failures++;
            $display("FAIL misalign_sticky: got m=%b req=%b, required m=1 req=0", misalign, imem.req);
        end
        imem.rdy = 1'b0;
`else
        checks++;
        if (misalign !== 1'b0 || imem.addr !== 32'h344) begin
            failures++;
            $display("FAIL misalign_off: got m=%b addr=%h, required m=0 addr=00000344", misalign, imem.addr);
        end
        imem.rdy = 1'b1; imem.data = 32'hBADBAD02;
        step();
        checks++;
        if (imem.addr !== 32'h40 || imem.req !== 1'b1) begin
            failures++;
            $display("FAIL misalign_mask: got addr=%h req=%b, required addr=00000040 req=1", imem.addr, imem.req);
        end
        imem.data = 32'h66666666;
        exp_q.push_back({32'h66666666, 32'h44});
        step();
        imem.rdy = 1'b0;
        step();
`endif
    endtask

    task automatic test_drain();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending instructions, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset_mid_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_transfer_stall();
        test_wrap();
        test_back_to_back();
        test_misalign();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
